// File: rtl/surfboard_pkg.sv
// Shared FSM encoding and term-sequencing tables for the 2x2 matrix multiplier.
package surfboard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_TERMS = 8;

  // Term k feeds a[A_IDX[k]] * b[B_IDX[k]]; even k starts element k>>1, odd k finishes it.
  localparam logic [1:0] A_IDX [NUM_TERMS] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  localparam logic [1:0] B_IDX [NUM_TERMS] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};

endpackage

// File: rtl/surfboard_mac.sv
// Single multiplier plus accumulator; acc shows the value the accumulator takes on this edge.
// Products and sums wrap modulo 2^W; SIGNED only selects how operands are interpreted.
module surfboard_mac #(
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         load,
  input  logic         acc_en,
  output logic [W-1:0] acc
);

  logic [W-1:0] prod;
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod = $signed(x) * $signed(y);
    end else begin : g_unsigned
      assign prod = x * y;
    end
  endgenerate

  assign acc_d = load ? prod : acc_q + prod;
  assign acc   = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/surfboard_seq.sv
// 2x2 matrix multiply C = A x B on one shared MAC; result valid 8 cycles after accept, held until out_ready.
// Optional handshake counter perf_cnt is built only when SURFBOARD_SEQ_PERF_EN is defined.
module surfboard_seq
  import surfboard_pkg::*;
#(
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] a,
  input  logic [4*W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] c,
`ifdef SURFBOARD_SEQ_PERF_EN
  output logic [31:0]    perf_cnt,
`endif
  output logic           busy
);

  state_e       state_q, state_d;
  logic [2:0]   k_q, k_d;
  logic [W-1:0] a_q [4];
  logic [W-1:0] b_q [4];
  logic [W-1:0] c_q [4];
  logic [W-1:0] mac_acc;
  logic         accept;
  logic         mac_step;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign mac_step  = (state_q == MAC);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MAC;
          k_d     = 3'd0;
        end
      end
      MAC: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'(NUM_TERMS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      for (int e = 0; e < 4; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        for (int e = 0; e < 4; e++) begin
          a_q[e] <= a[e*W +: W];
          b_q[e] <= b[e*W +: W];
        end
      end
      // Odd terms complete an element: the MAC output already holds the full sum.
      if (mac_step && k_q[0]) begin
        c_q[k_q[2:1]] <= mac_acc;
      end
    end
  end

  surfboard_mac #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (a_q[A_IDX[k_q]]),
    .y      (b_q[B_IDX[k_q]]),
    .load   (~k_q[0]),
    .acc_en (mac_step),
    .acc    (mac_acc)
  );

  generate
    for (genvar e = 0; e < 4; e++) begin : g_c
      assign c[e*W +: W] = c_q[e];
    end
  endgenerate

`ifdef SURFBOARD_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (out_valid && out_ready && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_surfboard_seq.sv
// Scoreboard bench for surfboard_seq: a signed and an unsigned instance share stimulus; truncated results match.
module tb_surfboard_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [4*W-1:0] a, b;

  logic           in_ready0, out_valid0, busy0;
  logic           in_ready1, out_valid1, busy1;
  logic [4*W-1:0] c0, c1;
`ifdef SURFBOARD_SEQ_PERF_EN
  logic [31:0]    perf0, perf1;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_edge = 0;
  int last_hs  = -1;
  bit ov_prev  = 1'b0;
  bit b2b      = 1'b0;
  logic [4*W-1:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  surfboard_seq #(.W(W), .SIGNED(1)) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .c         (c0),
`ifdef SURFBOARD_SEQ_PERF_EN
    .perf_cnt  (perf0),
`endif
    .busy      (busy0)
  );

  surfboard_seq #(.W(W), .SIGNED(0)) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .c         (c1),
`ifdef SURFBOARD_SEQ_PERF_EN
    .perf_cnt  (perf1),
`endif
    .busy      (busy1)
  );

  function automatic logic [4*W-1:0] pk(input logic [W-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expected results on every output handshake.
  always @(negedge clk) begin
    logic [4*W-1:0] e;
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready0) acc_edge = cyc + 1;
      if (out_valid0 && !ov_prev) check("latency", 64'(cyc - acc_edge), 64'd8);
      if (out_valid0 && out_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("c_signed", 64'(c0), 64'(e));
          check("c_unsigned", 64'(c1), 64'(e));
        end
        if (b2b) begin
          if (last_hs >= 0) check("spacing", 64'(cyc - last_hs), 64'd10);
          last_hs = cyc;
        end
      end
      ov_prev = out_valid0;
    end
  end

  task automatic wait_accept();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready0) begin
        @(posedge clk);
        return;
      end
    end
    timeout("accept");
  endtask

  // Leaves in_valid high; returns just after the acceptance edge.
  task automatic send(input logic [4*W-1:0] av, bv, ex, input bit push);
    @(posedge clk); #1;
    a = av;
    b = bv;
    in_valid = 1'b1;
    if (push) exp_q.push_back(ex);
    wait_accept();
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy0) return;
    end
    timeout("drain");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4*W-1:0] hold;
    bit seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'({in_ready0, in_ready1}), 64'd3);
    check("rst_out_valid", 64'({out_valid0, out_valid1}), 64'd0);
    check("rst_busy", 64'({busy0, busy1}), 64'd0);
    check("rst_c", 64'(c0 | c1), 64'd0);
`ifdef SURFBOARD_SEQ_PERF_EN
    check("rst_perf", 64'(perf0), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic, negative operands, wrap-around
    send(pk(16'd1, 16'd2, 16'd3, 16'd4), pk(16'd5, 16'd6, 16'd7, 16'd8),
         pk(16'd19, 16'd22, 16'd43, 16'd50), 1'b1);
    #1 in_valid = 1'b0;
    wait_drain();
    send(pk(16'hFFFF, 16'd2, 16'd0, 16'd1), pk(16'd3, 16'hFFFC, 16'd5, 16'd6),
         pk(16'd7, 16'd16, 16'd5, 16'd6), 1'b1);
    #1 in_valid = 1'b0;
    wait_drain();
    send(pk(16'hFFFF, 16'd0, 16'd0, 16'd0), pk(16'hFFFF, 16'd0, 16'd0, 16'd0),
         pk(16'h0001, 16'd0, 16'd0, 16'd0), 1'b1);
    #1 in_valid = 1'b0;
    wait_drain();

    // Back-pressure: result must hold while garbage operands are offered
    out_ready = 1'b0;
    hold = pk(16'd6, 16'd2, 16'd8, 16'd2);
    send(pk(16'd2, 16'd0, 16'd0, 16'd2), pk(16'd3, 16'd1, 16'd4, 16'd1), hold, 1'b1);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid0;
    end
    if (!seen) timeout("bp_out_valid");
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      a = ~a;
      b = b + 64'h0001_0001_0001_0001;
      in_valid = 1'b1;
      @(negedge clk);
      if (n % 5 == 0) begin
        check("bp_out_valid", 64'(out_valid0), 64'd1);
        check("bp_in_ready", 64'(in_ready0), 64'd0);
        check("bp_c_hold", 64'(c0), 64'(hold));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 64'(in_ready0), 64'd1);
    check("bp_release_valid", 64'(out_valid0), 64'd0);

    // Reset at MAC term k=4: aborted operation must not produce a result
    send(pk(16'd7, 16'd7, 16'd7, 16'd7), pk(16'd7, 16'd7, 16'd7, 16'd7), '0, 1'b0);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'({out_valid0, out_valid1}), 64'd0);
    check("midrst_in_ready", 64'({in_ready0, in_ready1}), 64'd3);
    check("midrst_busy", 64'({busy0, busy1}), 64'd0);
    check("midrst_c", 64'(c0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_idle", 64'(busy0), 64'd0);
    send(pk(16'd1, 16'd1, 16'd1, 16'd1), pk(16'd1, 16'hFFFF, 16'd2, 16'd3),
         pk(16'd3, 16'd2, 16'd3, 16'd2), 1'b1);
    #1 in_valid = 1'b0;
    wait_drain();

    // Back-to-back with in_valid and out_ready held high
    pulse_reset();
    b2b = 1'b1;
    last_hs = -1;
    send(pk(16'h7FFF, 16'd1, 16'd0, 16'd0), pk(16'd1, 16'd0, 16'd1, 16'd0),
         pk(16'h8000, 16'd0, 16'd0, 16'd0), 1'b1);
    send(pk(16'd3, 16'd0, 16'd0, 16'd3), pk(16'd4, 16'd0, 16'd0, 16'd5),
         pk(16'd12, 16'd0, 16'd0, 16'd15), 1'b1);
    send(pk(16'd0, 16'd1, 16'd1, 16'd0), pk(16'd9, 16'd8, 16'd7, 16'd6),
         pk(16'd7, 16'd6, 16'd9, 16'd8), 1'b1);
    #1 in_valid = 1'b0;
    wait_drain();
    b2b = 1'b0;
    check("b2b_count", 64'(last_hs >= 0), 64'd1);
`ifdef SURFBOARD_SEQ_PERF_EN
    check("perf_cnt", 64'(perf0), 64'd3);
    check("perf_cnt_u", 64'(perf1), 64'd3);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
